// File: rtl/cache_ram_arbiter.sv
// cache_ram_arbiter: lets NUM_BANKS cache banks share one RAM word port.
// Round-robin grant that is held across words, with a bounded hold limit.
//
// Ports:
//   CLK, RST (async, active-high)
//   bank_REN/WEN/addr/store : per-bank requests, bank i in slice i
//   bank_complete           : one-hot word-done pulse to the owner
//   bank_data               : RAM read data, broadcast
//   ram_REN/WEN/addr/store  : RAM-side request of the owner
//   ram_complete, ram_data  : RAM word done / read data
//   grant_valid, grant_id   : current owner
//   protocol_err            : sticky, owner drove REN and WEN together
module cache_ram_arbiter #(
  parameter  int NUM_BANKS = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int MAX_HOLD  = 8,
  localparam int ID_W      = $clog2(NUM_BANKS),
  localparam int HC_W      = $clog2(MAX_HOLD + 1)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_BANKS-1:0]          bank_REN,
  input  logic [NUM_BANKS-1:0]          bank_WEN,
  input  logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_store,
  output logic [NUM_BANKS-1:0]          bank_complete,
  output logic [DATA_W-1:0]             bank_data,
  output logic                          ram_REN,
  output logic                          ram_WEN,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_store,
  input  logic                          ram_complete,
  input  logic [DATA_W-1:0]             ram_data,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic                          protocol_err
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic [NUM_BANKS-1:0] req;
  logic [NUM_BANKS-1:0] own_oh;
  logic                 owned;
  logic                 own_req;
  logic                 others_req;
  logic                 both_err;
  logic [HC_W:0]        hc_inc;
  logic                 hold_hit;
  logic                 hold_sat;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      cand;
  logic                 found;

  logic [ADDR_W-1:0] addr_a  [NUM_BANKS];
  logic [DATA_W-1:0] store_a [NUM_BANKS];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_unpack
    assign addr_a[i]  = bank_addr[i*ADDR_W +: ADDR_W];
    assign store_a[i] = bank_store[i*DATA_W +: DATA_W];
  end

  assign req        = bank_REN | bank_WEN;
  assign owned      = (state == OWNED);
  assign own_oh     = NUM_BANKS'(1) << grant_id;
  assign own_req    = req[grant_id];
  assign others_req = |(req & ~own_oh);
  assign both_err   = bank_REN[grant_id] & bank_WEN[grant_id];

  // hold_cnt+1 is computed one bit wider so the limit test never wraps
  assign hc_inc   = {1'b0, hold_cnt} + (HC_W+1)'(1);
  assign hold_hit = hc_inc >= (HC_W+1)'(MAX_HOLD);
  assign hold_sat = hold_cnt >= HC_W'(MAX_HOLD);

  // first requester after the last owner, wrapping
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_BANKS; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_BANKS);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // outputs decode straight from the state flop so reset
  // drops the RAM strobes without waiting for a clock
  assign grant_valid   = owned;
  assign ram_REN       = owned & bank_REN[grant_id];
  assign ram_WEN       = owned & bank_WEN[grant_id];
  assign ram_addr      = owned ? addr_a[grant_id]  : '0;
  assign ram_store     = owned ? store_a[grant_id] : '0;
  assign bank_data     = ram_data;
  assign bank_complete = (owned & own_req & ram_complete)
                         ? own_oh : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      grant_id     <= '0;
      rr_ptr       <= ID_W'(NUM_BANKS - 1);
      hold_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= winner;
            rr_ptr   <= winner;
            hold_cnt <= '0;
            state    <= OWNED;
          end
        end
        OWNED: begin
          if (both_err) protocol_err <= 1'b1;
          if (!own_req) begin
            state <= IDLE;
          end else if (ram_complete) begin
            if (!hold_sat) hold_cnt <= hc_inc[HC_W-1:0];
            // preempt only at a word boundary
            if (hold_hit && others_req) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// tb_cache_ram_arbiter: bank/RAM models with a completion scoreboard
// and a spec-level grant model, random plus directed scenarios.
module tb_cache_ram_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 8;

  typedef struct packed {
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] store;
    logic [7:0]    gap;
  } word_t;

  logic CLK = 1'b0;
  logic RST;
  logic [NB-1:0]    d_ren, d_wen;
  logic [NB*AW-1:0] d_addr;
  logic [NB*DW-1:0] d_store;
  logic [NB-1:0]    bank_complete;
  logic [DW-1:0]    bank_data;
  logic             ram_REN, ram_WEN;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_store;
  logic             ram_complete;
  logic [DW-1:0]    ram_data;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             protocol_err;

  always #5 CLK = ~CLK;

  cache_ram_arbiter #(
    .NUM_BANKS(NB), .ADDR_W(AW),
    .DATA_W(DW), .MAX_HOLD(MH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .bank_REN(d_ren), .bank_WEN(d_wen),
    .bank_addr(d_addr), .bank_store(d_store),
    .bank_complete(bank_complete),
    .bank_data(bank_data),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_complete(ram_complete),
    .ram_data(ram_data),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .protocol_err(protocol_err)
  );

  function automatic logic [DW-1:0] rdfun(logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ (a * 32'h9E3779B1);
  endfunction

  assign ram_data = rdfun(ram_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h want %0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  word_t bq [NB][$];
  word_t eq [NB][$];
  int gseq[$], gcnt[$], es[$], ec[$];
  logic [NB-1:0] cmpl_s;
  int lat = 1;
  int rcnt = 0;
  logic spur = 1'b0;

  // monitor state: spec-level view of who should own the port
  int owner, last_owner, tenure;
  logic prev_gv, prev_oreq, prev_rel, err_exp;
  logic [NB-1:0] prev_req, req_m, ecmpl;
  logic oreq, err_set, rel, egv;
  word_t we;

  function automatic int rr_pick(logic [NB-1:0] r, int last);
    for (int k = 1; k <= NB; k++)
      if (r[(last + k) % NB]) return (last + k) % NB;
    return -1;
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      prev_gv = 0; prev_oreq = 0; prev_rel = 0;
      prev_req = '0; err_exp = 0; cmpl_s = '0;
      last_owner = NB - 1; owner = 0; tenure = 0;
    end else begin
      req_m = d_ren | d_wen;
      egv = prev_gv ? (prev_oreq && !prev_rel) : (|prev_req);
      chk("grant_valid", grant_valid, egv);
      if (grant_valid && !prev_gv) begin
        owner = rr_pick(prev_req, last_owner);
        chk("rr_winner", grant_id, owner);
        if (owner < 0) owner = int'(grant_id);
        last_owner = owner; tenure = 0;
        gseq.push_back(owner);
      end
      if (!grant_valid && prev_gv) gcnt.push_back(tenure);
      err_set = 0; oreq = 0;
      if (grant_valid) begin
        oreq = req_m[owner];
        chk("grant_id", grant_id, owner);
        chk("strobes", {ram_REN, ram_WEN},
            {d_ren[owner], d_wen[owner]});
        if (oreq) begin
          chk("pass_addr", ram_addr, d_addr[owner*AW +: AW]);
          chk("pass_store", ram_store, d_store[owner*DW +: DW]);
        end
        err_set = d_ren[owner] & d_wen[owner];
      end else begin
        chk("idle_out", {ram_REN, ram_WEN, ram_addr, ram_store},
            '0);
      end
      chk("protocol_err", protocol_err, err_exp);
      err_exp = err_exp | err_set;
      ecmpl = (grant_valid && oreq && ram_complete)
              ? NB'(1) << owner : '0;
      chk("bank_complete", bank_complete, ecmpl);
      rel = 0;
      if (ecmpl != 0 && bank_complete == ecmpl) begin
        if (eq[owner].size() == 0) begin
          chk("extra_complete", 1, 0);
        end else begin
          we = eq[owner].pop_front();
          chk("sb_op", {ram_REN, ram_WEN}, {we.ren, we.wen});
          chk("sb_addr", ram_addr, we.addr);
          if (we.wen) chk("sb_store", ram_store, we.store);
          if (we.ren) chk("sb_data", bank_data, rdfun(we.addr));
        end
        tenure++;
        rel = (tenure >= MH) && |(req_m & ~(NB'(1) << owner));
      end
      cmpl_s = bank_complete;
      prev_gv = grant_valid; prev_oreq = oreq;
      prev_rel = rel; prev_req = req_m;
    end
  end

  task automatic push_word(int b, logic r, logic w,
                           logic [AW-1:0] a, logic [DW-1:0] s);
    word_t x;
    x.ren = r; x.wen = w; x.addr = a; x.store = s; x.gap = 0;
    bq[b].push_back(x);
    eq[b].push_back(x);
  endtask

  task automatic push_gap(int b, int n);
    word_t x;
    x = '0; x.gap = 8'(n);
    bq[b].push_back(x);
  endtask

  task automatic tick();
    word_t w;
    logic stb;
    @(posedge CLK); #1;
    ram_complete = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (cmpl_s[b]) begin
        void'(bq[b].pop_front());
      end else if (bq[b].size() != 0 && bq[b][0].gap != 0) begin
        w = bq[b][0];
        if (w.gap <= 1) void'(bq[b].pop_front());
        else begin w.gap = w.gap - 1; bq[b][0] = w; end
      end
      if (bq[b].size() != 0 && bq[b][0].gap == 0) begin
        w = bq[b][0];
        d_ren[b] = w.ren; d_wen[b] = w.wen;
        d_addr[b*AW +: AW] = w.addr;
        d_store[b*DW +: DW] = w.store;
      end else begin
        d_ren[b] = 0; d_wen[b] = 0;
        d_addr[b*AW +: AW] = '0;
        d_store[b*DW +: DW] = '0;
      end
    end
    #1;
    stb = ram_REN | ram_WEN;
    if (lat == 0) begin
      ram_complete = stb ? ($urandom_range(0, 2) == 0)
                         : ($urandom_range(0, 7) == 0);
    end else if (stb) begin
      rcnt++;
      ram_complete = (rcnt >= lat);
      if (rcnt >= lat) rcnt = 0;
    end else begin
      rcnt = 0;
      ram_complete = spur;
    end
  endtask

  function automatic bit all_empty();
    for (int b = 0; b < NB; b++)
      if (bq[b].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(int budget);
    int quiet = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (all_empty() && !grant_valid) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        for (int b = 0; b < NB; b++)
          chk("sb_leftover", eq[b].size(), 0);
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL timeout: still busy after %0d cycles", budget);
  endtask

  task automatic check_grants(string nm);
    chk({nm, "_ngrants"}, gseq.size(), es.size());
    for (int i = 0; i < es.size() && i < gseq.size(); i++)
      chk({nm, "_order"}, gseq[i], es[i]);
    chk({nm, "_ntenure"}, gcnt.size(), ec.size());
    for (int i = 0; i < ec.size() && i < gcnt.size(); i++)
      chk({nm, "_words"}, gcnt[i], ec[i]);
    gseq.delete(); gcnt.delete();
  endtask

  initial begin
    RST = 1'b1;
    d_ren = '0; d_wen = '0; d_addr = '0; d_store = '0;
    ram_complete = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_strb", {ram_REN, ram_WEN}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_cmpl", bank_complete, 0);
    chk("rst_err", protocol_err, 0);
    chk("rst_data", bank_data, 0);
    @(negedge CLK); #1 RST = 1'b0;

    // complete with nobody owning the port is dropped
    lat = 1; spur = 1'b1;
    repeat (3) tick();
    spur = 1'b0;

    // round robin from reset
    gseq.delete(); gcnt.delete();
    push_word(0, 1, 0, 32'h10, 0);
    push_word(1, 0, 1, 32'h20, 32'hA1);
    push_word(3, 1, 0, 32'h30, 0);
    run_until_idle(100);
    es = {0, 1, 3}; ec = {1, 1, 1};
    check_grants("rr");

    // single requester, one-cycle grant latency
    lat = 3;
    for (int k = 0; k < 4; k++)
      push_word(2, 1, 0, 32'h100 + k, 0);
    tick();
    @(negedge CLK);
    chk("t1_first_idle", grant_valid, 0);
    tick();
    @(negedge CLK);
    chk("t1_granted", {grant_valid, grant_id, ram_REN}, 4'b1101);
    run_until_idle(100);
    es = {2}; ec = {4};
    check_grants("single");

    // preemption after MAX_HOLD words
    lat = 2;
    for (int k = 0; k < 20; k++)
      push_word(0, 0, 1, 32'h200 + k, $urandom);
    push_gap(1, 7);
    push_word(1, 1, 0, 32'h300, 0);
    run_until_idle(200);
    es = {0, 1, 0}; ec = {8, 1, 12};
    check_grants("preempt");

    // alone: no preemption, hold counter saturates
    lat = 1;
    for (int k = 0; k < 12; k++)
      push_word(3, 1, 0, 32'h400 + k, 0);
    run_until_idle(100);
    es = {3}; ec = {12};
    check_grants("alone");
    chk("hold_sat", dut.hold_cnt, MH);

    // read then write without a gap keeps the grant
    lat = 2;
    for (int k = 0; k < 4; k++)
      push_word(1, 1, 0, 32'h500 + k, 0);
    for (int k = 0; k < 4; k++)
      push_word(1, 0, 1, 32'h600 + k, $urandom);
    run_until_idle(100);
    es = {1}; ec = {8};
    check_grants("rw");
    chk("rw_err", protocol_err, 0);

    // random traffic
    lat = 0;
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < NB; b++) begin
        int nw;
        bit op;
        nw = $urandom_range(0, 10);
        if ($urandom_range(0, 1) == 1)
          push_gap(b, $urandom_range(2, 8));
        for (int k = 0; k < nw; k++) begin
          op = 1'($urandom_range(0, 1));
          push_word(b, !op, op, $urandom, $urandom);
          if ($urandom_range(0, 5) == 0)
            push_gap(b, $urandom_range(2, 4));
        end
      end
      run_until_idle(3000);
    end
    gseq.delete(); gcnt.delete();

    // protocol error, then reset mid-word
    lat = 4;
    push_word(2, 1, 1, 32'h700, 32'hBEEF);
    for (int k = 0; k < 3; k++)
      push_word(2, 1, 0, 32'h701 + k, 0);
    repeat (7) tick();
    @(negedge CLK);
    chk("err_set", protocol_err, 1);
    chk("mid_word", ram_REN, 1);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("arst_strb", {ram_REN, ram_WEN}, 0);
    chk("arst_addr", ram_addr, 0);
    chk("arst_gv", {grant_valid, grant_id}, 0);
    chk("arst_err", protocol_err, 0);
    chk("arst_cmpl", bank_complete, 0);
    for (int b = 0; b < NB; b++) begin
      bq[b].delete(); eq[b].delete();
    end
    d_ren = '0; d_wen = '0; d_addr = '0; d_store = '0;
    ram_complete = 1'b0; rcnt = 0; lat = 1;
    gseq.delete(); gcnt.delete();
    push_word(3, 1, 0, 32'h800, 0);
    push_word(0, 1, 0, 32'h900, 0);
    @(negedge CLK); #1 RST = 1'b0;
    run_until_idle(100);
    es = {0, 3}; ec = {1, 1};
    check_grants("post_rst");
    chk("post_rst_err", protocol_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_ram_arbiter.md
# cache_ram_arbiter

- Shares the single backing-RAM word port between `NUM_BANKS` cache banks.
- Each bank presents its RAM request signals: REN/WEN, address and store word. The bank holds the request until it sees a per-bank complete pulse, then advances to its next word.
- The block grants one bank at a time with round-robin priority. It keeps a grant across consecutive words of a block pull and victim eject. A bounded hold limit preempts a bank at a word boundary so other banks are not starved.
- It sits between the bank array and the RAM controller.

## Interface
Parameters:
- `NUM_BANKS`, 4: number of requesting banks (≥2).
- `ADDR_W`, 32: RAM word address width.
- `DATA_W`, 32: RAM word width (CACHE_RW_SIZE).
- `MAX_HOLD`, 8: completed words one grant may take while another bank waits (≥1).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK`  in  1  clock.
- `RST`  in  1  asynchronous active-high reset.
- `bank_REN`  in  NUM_BANKS  per-bank read request.
- `bank_WEN`  in  NUM_BANKS  per-bank write request.
- `bank_addr`  in  NUM_BANKS*ADDR_W  per-bank address, bank i at bits [i*ADDR_W +: ADDR_W].
- `bank_store`  in  NUM_BANKS*DATA_W  per-bank write data, same packing.
- `bank_complete`  out  NUM_BANKS  one-hot pulse to the granted bank when its word finishes.
- `bank_data`  out  DATA_W  read data, broadcast to all banks.
- `ram_REN`  out  1  read strobe to RAM.
- `ram_WEN`  out  1  write strobe to RAM.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_store`  out  DATA_W  RAM write data.
- `ram_complete`  in  1  RAM finished the current word.
- `ram_data`  in  DATA_W  RAM read data, valid with `ram_complete`.
- `grant_valid`  out  1  a bank currently owns the port.
- `grant_id`  out  $clog2(NUM_BANKS)  owning bank.
- `protocol_err`  out  1  sticky; set when the granted bank asserts REN and WEN together.

## Operation
Request definition:
- `req[i] = bank_REN[i] | bank_WEN[i]`.

Registered state:
- FSM state: IDLE or OWNED.
- `grant_id`.
- `rr_ptr`, the last owner.
- `hold_cnt`, width $clog2(MAX_HOLD+1).
- `protocol_err`.

IDLE:
- Outputs: `ram_*` = 0, `bank_complete` = 0, `grant_valid` = 0.
- If any `req` is set, pick the first requester searching `rr_ptr+1, rr_ptr+2, …` modulo NUM_BANKS.
- Register it into `grant_id`, set `rr_ptr <= winner`, clear `hold_cnt`, go to OWNED.

OWNED:
- `ram_REN/ram_WEN/ram_addr/ram_store` are combinational passthrough of bank `grant_id`. `grant_valid` = 1.
- If `req[grant_id]` = 0: the RAM strobes are 0 this cycle, and the next state is IDLE.
- On `ram_complete` with `req[grant_id]` = 1:
  - `bank_complete[grant_id]` = 1 in the same cycle.
  - `hold_cnt` increments.
- Preemption: if, on that complete, `hold_cnt+1 >= MAX_HOLD` and any other bank requests, the next state is IDLE.
  - `rr_ptr` already equals the owner, so the next arbitration favours the other banks.
- If no other bank requests, ownership continues and `hold_cnt` saturates at MAX_HOLD.

Common rules:
- `bank_data` = `ram_data` every cycle, unregistered.
- `ram_complete` in IDLE, or while `req[grant_id]` = 0, is ignored: no `bank_complete` is issued.
- `bank_REN` and `bank_WEN` both high on the owner:
  - Both are forwarded unchanged.
  - `protocol_err` is set and stays set until reset.
- Preemption and release happen only at a `ram_complete` edge or when the owner drops its request. The RAM strobes never switch banks mid-word.

## Timing
Reset values:
- State IDLE, `grant_id` = 0, `rr_ptr` = NUM_BANKS-1 (bank 0 wins first), `hold_cnt` = 0.
- All outputs are 0.

Latency and handshake:
- Arbitration latency is 1 cycle: a request first seen in IDLE at cycle t drives `ram_REN/WEN` from cycle t+1.
- Re-grant after a release or preemption costs one IDLE cycle, with the strobes low in that cycle.
- Complete return is 0 cycles: `bank_complete` follows `ram_complete` in the same cycle.

Bank behaviour the arbiter depends on:
- A bank holds REN/WEN and its address stable until its complete pulse, then updates them on the next edge.
- Continued ownership requires no idle cycle between words.

Reset behaviour:
- Reset mid-word returns the block to IDLE immediately. The RAM strobes drop asynchronously and the in-flight word is abandoned.

Wrap-around:
- `rr_ptr` = NUM_BANKS-1 searches from bank 0.

## Test plan
- Single requester: bank 2 holds REN for 4 words, RAM completes every 3 cycles. Expect `grant_id`=2 from the cycle after the request. Expect 4 `bank_complete[2]` pulses with `bank_data` equal to the RAM data each time, then IDLE once REN drops.
- Round robin: banks 0, 1 and 3 each request one word in the same cycle from reset. Expect grant order 0, 1, 3, each separated by one IDLE cycle.
- Preemption: bank 0 streams 20 words while bank 1 requests at word 3, MAX_HOLD=8. Expect bank 0 to be released after its 8th complete and bank 1 granted two cycles later. Expect bank 0 re-granted after bank 1's request drops.
- No preemption when alone: bank 3 streams 12 words with no other requesters. Expect a continuous grant, `hold_cnt` saturating at 8, and 12 completes.
- Read then write hand-off: bank 1 issues 4 REN words and then, with no gap, 4 WEN words. Expect the grant held and `ram_WEN`/`ram_store` to follow bank 1. Expect `protocol_err` to stay 0.
- Error and reset: the owner asserts REN and WEN together, so `protocol_err` = 1. Then assert `RST` mid-word: all outputs go to 0 immediately, the next grant after reset goes to bank 0, and `protocol_err` = 0.
